dmem_responder: RTL and testbench

Memory-side responder for the processor's MEM-stage data port. It accepts one read or write request per valid/ready handshake and returns a response after a fixed, parameterised latency. It holds the response until the initiator accepts it. It owns a word-addressed storage array with byte-lane write enables, replacing the single-cycle data memory so that the pipeline can be run against realistic memory timing.

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_byte_ram.sv | 30 +++
 rtl/dmem_responder.sv | 82 ++++++++
 tb/tb_dmem_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and default parameters for the data-memory responder
package dmem_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LATENCY = 2;
  localparam int LANES = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: single-port word RAM with byte write enables and write-first registered read
// clk/rst: clock and async active-low reset (read register only; storage is never reset)
// en: access strobe; we: byte-lane write enables; addr/wdata: access word
// rdata: registered word after the access, including any merged write lanes
module dmem_byte_ram import dmem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] merged;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign merged[8*g +: 8] = we[g] ? wdata[8*g +: 8] : mem[addr][8*g +: 8];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (en && we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else if (en) rdata <= merged;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with fixed latency and held responses
// clk/rst: clock and async active-low reset
// req_*: request channel (write flag, word address, write data, byte strobes)
// resp_*: response channel (write echo, read data or post-merge word)
// busy: high whenever a request is in flight or a response is pending
module dmem_responder import dmem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  state_t            state;
  logic [3:0]        cnt;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  strb_q;
  logic              accept, in_wait, commit, cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [LANES-1:0]  cur_we;
  assign req_ready = rst && (state == IDLE || (state == RESP && resp_ready));
  assign accept = req_valid && req_ready;
  assign in_wait = state == WAIT;
  // single-cycle latency commits straight from the request lines on the accepting edge
  assign commit = (in_wait && cnt == 4'd0) || (accept && LATENCY == 1);
  assign cur_write = in_wait ? write_q : req_write;
  assign cur_addr = in_wait ? addr_q : req_addr;
  assign cur_wdata = in_wait ? wdata_q : req_wdata;
  assign cur_we = cur_write ? (in_wait ? strb_q : req_wstrb) : '0;
  assign resp_valid = state == RESP;
  assign busy = state != IDLE;
  dmem_byte_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (commit),
    .we    (cur_we),
    .addr  (cur_addr),
    .wdata (cur_wdata),
    .rdata (resp_rdata)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      resp_write <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        strb_q <= req_wstrb;
        state <= LATENCY == 1 ? RESP : WAIT;
        cnt <= CNT_INIT;
      end else if (in_wait) begin
        state <= cnt == 4'd0 ? RESP : WAIT;
        cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      end else if (state == RESP && resp_ready) begin
        state <= IDLE;
      end
      if (commit) resp_write <= cur_write;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a word-array model
module tb_dmem_responder;
  logic clk = 1'b0, rst = 1'b0, sel = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [7:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_wstrb = '0;
  logic [1:0] rr, rv, rw, by;
  logic [31:0] rd [2];
  logic req_ready, resp_valid, resp_write, busy;
  logic [31:0] resp_rdata;
  bit [31:0] mm [2][256];
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rr[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_write(rw[0]), .resp_rdata(rd[0]), .busy(by[0])
  );
  dmem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rr[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_write(rw[1]), .resp_rdata(rd[1]), .busy(by[1])
  );
  assign req_ready = rr[sel];
  assign resp_valid = rv[sel];
  assign resp_write = rw[sel];
  assign resp_rdata = rd[sel];
  assign busy = by[sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else passed++;
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] s);
    bit [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic txn(input bit wr, input bit [7:0] a, input bit [31:0] d, input bit [3:0] s,
                     input int hold, output logic [31:0] got);
    int lat = sel ? 1 : 2;
    int n = 0;
    bit [31:0] exp = wr ? merge(mm[sel][a], d, s) : mm[sel][a];
    if (wr) mm[sel][a] = exp;
    @(negedge clk);
    req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1; resp_ready = 1'b0;
    #1 chk("req_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_write = 1'($urandom); req_addr = 8'($urandom);
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    chk("latency", n, lat);
    chk("resp_write", resp_write, wr);
    chk("resp_rdata", resp_rdata, exp);
    got = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rdata", resp_rdata, exp);
      chk("hold_ready", req_ready, 0);
      chk("hold_valid", resp_valid, 1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("idle_after", busy, 0);
  endtask

  initial begin
    #200000 $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    bit [31:0] old;
    int got_cyc[$];
    logic [31:0] got_d[$];
    int issued;
    bit acc;
    repeat (3) @(negedge clk);
    chk("rst_valid", resp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", resp_rdata, 0);
    rst = 1'b1;
    #1 chk("ready_release", req_ready, 1);

    txn(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, got);
    chk("wr_deadbeef", got, 32'hDEADBEEF);
    txn(0, 8'h10, 32'h0, 4'h0, 0, got);
    chk("rd_deadbeef", got, 32'hDEADBEEF);
    txn(1, 8'h10, 32'h11223344, 4'b0101, 0, got);
    txn(0, 8'h10, 32'h0, 4'h0, 0, got);
    chk("rd_strobe", got, 32'hDE22BE44);
    txn(1, 8'h10, 32'hCAFEF00D, 4'h0, 0, got);
    chk("wstrb_zero", got, 32'hDE22BE44);
    txn(0, 8'h10, 32'h0, 4'h0, 5, got);

    for (int a = 0; a < 16; a++) txn(1, 8'(a), $urandom, 4'hF, $urandom_range(0, 2), got);
    for (int k = 0; k < 30; k++)
      txn(1'($urandom), 8'($urandom_range(0, 15)), $urandom, 4'($urandom), $urandom_range(0, 2), got);

    @(negedge clk);
    issued = 0;
    req_write = 1'b0; req_addr = 8'h00; req_valid = 1'b1; resp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin got_cyc.push_back(c); got_d.push_back(resp_rdata); end
      acc = req_valid && req_ready;
      @(posedge clk);
      #1 if (acc) begin
        issued++;
        req_addr = 8'(issued);
        if (issued == 4) req_valid = 1'b0;
      end
      @(negedge clk);
    end
    resp_ready = 1'b0;
    chk("b2b_count", got_cyc.size(), 4);
    foreach (got_cyc[k]) begin
      chk("b2b_cycle", got_cyc[k], 2 * (k + 1));
      chk("b2b_data", got_d[k], mm[0][k]);
    end

    txn(1, 8'h20, $urandom, 4'hF, 0, got);
    old = mm[0][8'h20];
    @(negedge clk);
    req_write = 1'b1; req_addr = 8'h20; req_wdata = ~old; req_wstrb = 4'hF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_in_wait", busy, 1);
    rst = 1'b0;
    #1 chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_rdata", resp_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_release", req_ready, 1);
    txn(0, 8'h20, 32'h0, 4'h0, 0, got);
    chk("mid_old_value", got, old);

    sel = 1'b1;
    txn(1, 8'h30, 32'h0BADF00D, 4'hF, 0, got);
    txn(1, 8'h30, 32'hA5A5A5A5, 4'b1010, 2, got);
    txn(0, 8'h30, 32'h0, 4'h0, 0, got);
    chk("l1_strobe", got, 32'hA5ADA50D);
    for (int a = 0; a < 8; a++) txn(1, 8'(a), $urandom, 4'hF, 0, got);
    for (int k = 0; k < 12; k++)
      txn(1'($urandom), 8'($urandom_range(0, 7)), $urandom, 4'($urandom), $urandom_range(0, 2), got);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
